// File: rtl/v_row_assembler_pkg.sv
// Shared types for the V-row assembler: the V row type, the element width,
// the default maximum row count and the FSM state encoding.
`ifndef MAX_SEQ_LENGTH
`define MAX_SEQ_LENGTH 8
`endif

package v_row_assembler_pkg;

  localparam int ELEM_WIDTH  = 8;
  localparam int V_VEC_ELEMS = 16;

  typedef logic [V_VEC_ELEMS*ELEM_WIDTH-1:0] V_VECTOR_T;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_PUSH = 2'd2,
    S_DONE = 2'd3
  } v_asm_state_t;

endpackage

// File: rtl/v_beat_packer.sv
// Row register plus beat index: drops each accepted beat into its slot of
// the row and flags when the current beat is the last one of the row.
module v_beat_packer
  import v_row_assembler_pkg::*;
#(
  parameter int BEAT_ELEMS = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           clear,
  input  logic                           write,
  input  logic [BEAT_ELEMS*ELEM_WIDTH-1:0] beat_data,
  output V_VECTOR_T                      row,
  output logic                           last_beat
);

  localparam int VEC_ELEMS     = $bits(V_VECTOR_T) / ELEM_WIDTH;
  localparam int BEATS_PER_ROW = VEC_ELEMS / BEAT_ELEMS;
  localparam int BEAT_W        = BEAT_ELEMS * ELEM_WIDTH;
  localparam int IDX_W         = (BEATS_PER_ROW > 1) ? $clog2(BEATS_PER_ROW) : 1;

  logic [IDX_W-1:0] beat_idx;

  assign last_beat = (beat_idx == IDX_W'(BEATS_PER_ROW - 1));

  // The index wraps on the last beat so the next row starts at slot 0
  // without needing an explicit clear between rows of the same tile.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row      <= '0;
      beat_idx <= '0;
    end else if (clear) begin
      row      <= '0;
      beat_idx <= '0;
    end else if (write) begin
      for (int b = 0; b < BEATS_PER_ROW; b++) begin
        if (beat_idx == IDX_W'(b)) begin
          row[b*BEAT_W +: BEAT_W] <= beat_data;
        end
      end
      beat_idx <= last_beat ? '0 : beat_idx + IDX_W'(1);
    end
  end

endmodule

// File: rtl/v_row_assembler.sv
// Packs narrow INT8 read-return beats into full V rows, pushes each row into
// the V FIFO and pulses done once the requested number of rows is written.
module v_row_assembler
  import v_row_assembler_pkg::*;
#(
  parameter int BEAT_ELEMS = 8,
  parameter int NUM_ROWS   = `MAX_SEQ_LENGTH
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              start,
  input  logic [$clog2(NUM_ROWS):0]         num_rows,
  input  logic                              beat_valid,
  output logic                              beat_ready,
  input  logic [BEAT_ELEMS*ELEM_WIDTH-1:0]  beat_data,
  output logic                              write_enable,
  input  logic                              sram_ready,
  output V_VECTOR_T                         write_data,
  output logic                              busy,
  output logic                              done,
  output logic [$clog2(NUM_ROWS):0]         rows_written
);

  localparam int CNT_W = $clog2(NUM_ROWS) + 1;

  v_asm_state_t     state;
  logic [CNT_W-1:0] rows_target;
  logic [CNT_W-1:0] start_count;
  logic             beat_fire;
  logic             packer_clear;
  logic             last_beat;
  logic             last_row;

  // Oversized requests are clamped to what the V FIFO tile can hold.
  assign start_count  = (num_rows > CNT_W'(NUM_ROWS)) ? CNT_W'(NUM_ROWS) : num_rows;
  assign beat_fire    = beat_valid && beat_ready;
  assign packer_clear = (state == S_IDLE) && start;
  assign last_row     = ((rows_written + CNT_W'(1)) == rows_target);

  v_beat_packer #(
    .BEAT_ELEMS (BEAT_ELEMS)
  ) u_packer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (packer_clear),
    .write     (beat_fire),
    .beat_data (beat_data),
    .row       (write_data),
    .last_beat (last_beat)
  );

  // Handshake outputs are registered alongside the state so that no input
  // reaches an output combinationally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      rows_target  <= '0;
      rows_written <= '0;
      beat_ready   <= 1'b0;
      write_enable <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            rows_target  <= start_count;
            rows_written <= '0;
            busy         <= 1'b1;
            if (start_count == '0) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state      <= S_FILL;
              beat_ready <= 1'b1;
            end
          end
        end

        S_FILL: begin
          if (beat_fire && last_beat) begin
            state        <= S_PUSH;
            beat_ready   <= 1'b0;
            write_enable <= 1'b1;
          end
        end

        S_PUSH: begin
          if (sram_ready) begin
            rows_written <= rows_written + CNT_W'(1);
            write_enable <= 1'b0;
            if (last_row) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state      <= S_FILL;
              beat_ready <= 1'b1;
            end
          end
        end

        S_DONE: begin
          state <= S_IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end

        default: begin
          state        <= S_IDLE;
          beat_ready   <= 1'b0;
          write_enable <= 1'b0;
          busy         <= 1'b0;
          done         <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_v_row_assembler.sv
// Directed self-checking bench for v_row_assembler with 16-element rows and
// 4-element beats (4 beats per row) and an 8-row tile limit.
module tb_v_row_assembler;
  import v_row_assembler_pkg::*;

  localparam int BEAT_ELEMS = 4;
  localparam int NUM_ROWS   = 8;
  localparam int CNT_W      = $clog2(NUM_ROWS) + 1;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [CNT_W-1:0] num_rows;
  logic             beat_valid;
  logic             beat_ready;
  logic [31:0]      beat_data;
  logic             write_enable;
  logic             sram_ready;
  V_VECTOR_T        write_data;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] rows_written;

  int tests;
  int failed;
  int cyc;
  int beat_no;

  v_row_assembler #(
    .BEAT_ELEMS (BEAT_ELEMS),
    .NUM_ROWS   (NUM_ROWS)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .num_rows     (num_rows),
    .beat_valid   (beat_valid),
    .beat_ready   (beat_ready),
    .beat_data    (beat_data),
    .write_enable (write_enable),
    .sram_ready   (sram_ready),
    .write_data   (write_data),
    .busy         (busy),
    .done         (done),
    .rows_written (rows_written)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Beat n carries elements 4n..4n+3, so element i of any row equals its
  // absolute element position (mod 256).
  function automatic logic [31:0] beat_word(input int n);
    logic [31:0] w;
    for (int e = 0; e < 4; e++) w[8*e +: 8] = 8'(n*4 + e);
    return w;
  endfunction

  function automatic V_VECTOR_T exp_row(input int first);
    V_VECTOR_T v;
    for (int i = 0; i < 16; i++) v[8*i +: 8] = 8'(first + i);
    return v;
  endfunction

  task automatic clock_cycle();
    logic fire;
    beat_data = beat_word(beat_no);
    fire = beat_valid && beat_ready;
    @(posedge clk);
    #1;
    if (fire) beat_no++;
    cyc++;
  endtask

  task automatic start_tile(input logic [CNT_W-1:0] n);
    num_rows = n;
    start    = 1'b1;
    clock_cycle();
    start    = 1'b0;
    num_rows = '1;
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    start      = 1'b0;
    num_rows   = '0;
    beat_valid = 1'b0;
    beat_data  = '0;
    sram_ready = 1'b0;
    beat_no    = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    clock_cycle();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    tests++; if (beat_ready !== 1'b0) begin failed++; $display("[TB] FAIL reset_beat_ready got %b want 0", beat_ready); end
    tests++; if (write_enable !== 1'b0) begin failed++; $display("[TB] FAIL reset_write_enable got %b want 0", write_enable); end
    tests++; if (write_data !== '0) begin failed++; $display("[TB] FAIL reset_write_data got %h want 0", write_data); end
    tests++; if (busy !== 1'b0) begin failed++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
    tests++; if (done !== 1'b0) begin failed++; $display("[TB] FAIL reset_done got %b want 0", done); end
    tests++; if (rows_written !== '0) begin failed++; $display("[TB] FAIL reset_rows_written got %0d want 0", rows_written); end
    do_reset();
  endtask

  task automatic test_two_rows();
    int        nw;
    int        dn;
    int        wcyc[2];
    V_VECTOR_T wdat[2];
    nw = 0; dn = 0;
    do_reset();
    sram_ready = 1'b1;
    beat_valid = 1'b1;
    start_tile(CNT_W'(2));
    tests++; if (beat_ready !== 1'b1) begin failed++; $display("[TB] FAIL two_rows_fill_latency beat_ready got %b want 1", beat_ready); end
    for (int c = 0; c < 40; c++) begin
      clock_cycle();
      if (write_enable) begin
        if (nw < 2) begin wcyc[nw] = cyc; wdat[nw] = write_data; end
        nw++;
      end
      if (done) dn++;
      if (dn > 0 && !busy) break;
    end
    tests++; if (busy !== 1'b0) begin failed++; $display("[TB] FAIL two_rows_timeout busy got %b want 0", busy); end
    tests++; if (nw !== 2) begin failed++; $display("[TB] FAIL two_rows_push_count got %0d want 2", nw); end
    if (nw >= 2) begin
      tests++; if (wdat[0] !== exp_row(0)) begin failed++; $display("[TB] FAIL two_rows_row0 got %h want %h", wdat[0], exp_row(0)); end
      tests++; if (wdat[1] !== exp_row(16)) begin failed++; $display("[TB] FAIL two_rows_row1 got %h want %h", wdat[1], exp_row(16)); end
      tests++; if (wcyc[1] - wcyc[0] !== 5) begin failed++; $display("[TB] FAIL two_rows_spacing got %0d want 5", wcyc[1] - wcyc[0]); end
    end
    tests++; if (dn !== 1) begin failed++; $display("[TB] FAIL two_rows_done_pulses got %0d want 1", dn); end
    tests++; if (rows_written !== CNT_W'(2)) begin failed++; $display("[TB] FAIL two_rows_rows_written got %0d want 2", rows_written); end
    beat_valid = 1'b0;
  endtask

  task automatic test_stall();
    V_VECTOR_T held;
    int        waited;
    do_reset();
    sram_ready = 1'b0;
    beat_valid = 1'b1;
    start_tile(CNT_W'(1));
    waited = 0;
    while (!write_enable && waited < 20) begin clock_cycle(); waited++; end
    tests++; if (write_enable !== 1'b1) begin failed++; $display("[TB] FAIL stall_reach_push write_enable got %b want 1", write_enable); end
    held = write_data;
    tests++; if (held !== exp_row(0)) begin failed++; $display("[TB] FAIL stall_row got %h want %h", held, exp_row(0)); end
    for (int s = 0; s < 6; s++) begin
      clock_cycle();
      tests++; if (write_enable !== 1'b1) begin failed++; $display("[TB] FAIL stall_we_%0d got %b want 1", s, write_enable); end
      tests++; if (write_data !== held) begin failed++; $display("[TB] FAIL stall_data_%0d got %h want %h", s, write_data, held); end
      tests++; if (beat_ready !== 1'b0) begin failed++; $display("[TB] FAIL stall_beat_ready_%0d got %b want 0", s, beat_ready); end
    end
    sram_ready = 1'b1;
    clock_cycle();
    tests++; if (write_enable !== 1'b0) begin failed++; $display("[TB] FAIL stall_release_we got %b want 0", write_enable); end
    tests++; if (rows_written !== CNT_W'(1)) begin failed++; $display("[TB] FAIL stall_release_rows got %0d want 1", rows_written); end
    tests++; if (done !== 1'b1) begin failed++; $display("[TB] FAIL stall_release_done got %b want 1", done); end
    beat_valid = 1'b0;
    clock_cycle();
  endtask

  task automatic test_toggle_valid();
    do_reset();
    sram_ready = 1'b1;
    start_tile(CNT_W'(1));
    for (int i = 0; i < 8; i++) begin
      beat_valid = (i % 2 == 1);
      clock_cycle();
      if (i == 6) begin
        tests++; if (write_enable !== 1'b0) begin failed++; $display("[TB] FAIL toggle_early_we got %b want 0", write_enable); end
      end
    end
    tests++; if (write_enable !== 1'b1) begin failed++; $display("[TB] FAIL toggle_we got %b want 1", write_enable); end
    tests++; if (write_data !== exp_row(0)) begin failed++; $display("[TB] FAIL toggle_row got %h want %h", write_data, exp_row(0)); end
    beat_valid = 1'b0;
    clock_cycle();
    tests++; if (done !== 1'b1) begin failed++; $display("[TB] FAIL toggle_done got %b want 1", done); end
    clock_cycle();
  endtask

  task automatic test_zero_rows();
    int we_seen;
    we_seen = 0;
    do_reset();
    sram_ready = 1'b1;
    beat_valid = 1'b1;
    start_tile(CNT_W'(0));
    // A zero-row tile goes straight to DONE on the start edge.
    tests++; if (done !== 1'b1) begin failed++; $display("[TB] FAIL zero_done got %b want 1", done); end
    tests++; if (busy !== 1'b1) begin failed++; $display("[TB] FAIL zero_busy got %b want 1", busy); end
    if (write_enable) we_seen++;
    for (int c = 0; c < 4; c++) begin
      clock_cycle();
      if (write_enable) we_seen++;
    end
    tests++; if (we_seen !== 0) begin failed++; $display("[TB] FAIL zero_write_enable got %0d cycles want 0", we_seen); end
    tests++; if (done !== 1'b0 || busy !== 1'b0) begin failed++; $display("[TB] FAIL zero_idle done=%b busy=%b want 0 0", done, busy); end
    tests++; if (rows_written !== '0) begin failed++; $display("[TB] FAIL zero_rows_written got %0d want 0", rows_written); end
    beat_valid = 1'b0;
  endtask

  task automatic test_overflow();
    int pushes;
    int dn;
    pushes = 0; dn = 0;
    do_reset();
    sram_ready = 1'b1;
    beat_valid = 1'b1;
    start_tile(CNT_W'(NUM_ROWS + 5));
    for (int c = 0; c < 200; c++) begin
      clock_cycle();
      if (write_enable) pushes++;
      if (done) dn++;
      if (dn > 0 && !busy) break;
    end
    tests++; if (pushes !== NUM_ROWS) begin failed++; $display("[TB] FAIL overflow_pushes got %0d want %0d", pushes, NUM_ROWS); end
    tests++; if (dn !== 1) begin failed++; $display("[TB] FAIL overflow_done got %0d want 1", dn); end
    tests++; if (rows_written !== CNT_W'(NUM_ROWS)) begin failed++; $display("[TB] FAIL overflow_rows_written got %0d want %0d", rows_written, NUM_ROWS); end
    beat_valid = 1'b0;
  endtask

  task automatic test_reset_mid_tile();
    int waited;
    do_reset();
    sram_ready = 1'b1;
    beat_valid = 1'b1;
    start_tile(CNT_W'(2));
    waited = 0;
    while (beat_no < 6 && waited < 30) begin clock_cycle(); waited++; end
    tests++; if (beat_no !== 6) begin failed++; $display("[TB] FAIL midreset_reach got %0d beats want 6", beat_no); end
    rst_n = 1'b0;
    #1;
    tests++; if (beat_ready !== 1'b0 || write_enable !== 1'b0 || busy !== 1'b0 || done !== 1'b0)
      begin failed++; $display("[TB] FAIL midreset_ctrl ready=%b we=%b busy=%b done=%b want 0 0 0 0", beat_ready, write_enable, busy, done); end
    tests++; if (write_data !== '0) begin failed++; $display("[TB] FAIL midreset_data got %h want 0", write_data); end
    tests++; if (rows_written !== '0) begin failed++; $display("[TB] FAIL midreset_rows got %0d want 0", rows_written); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    beat_no = 100;
    clock_cycle();
    start_tile(CNT_W'(1));
    waited = 0;
    while (!write_enable && waited < 20) begin clock_cycle(); waited++; end
    tests++; if (write_data !== exp_row(400)) begin failed++; $display("[TB] FAIL midreset_new_row got %h want %h", write_data, exp_row(400)); end
    clock_cycle();
    tests++; if (rows_written !== CNT_W'(1) || done !== 1'b1) begin failed++; $display("[TB] FAIL midreset_finish rows=%0d done=%b want 1 1", rows_written, done); end
    beat_valid = 1'b0;
    clock_cycle();
  endtask

  initial begin
    tests  = 0;
    failed = 0;
    cyc    = 0;
    do_reset();
    test_reset();
    test_two_rows();
    test_stall();
    test_toggle_valid();
    test_zero_rows();
    test_overflow();
    test_reset_mid_tile();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
